// File: rtl/icache_refill_reader.sv
// ICache refill/uncached-fetch responder: accepts one miss request, issues one
// INCR read burst on a 32-bit channel and returns the assembled 512-bit line.
module icache_refill_reader #(
   parameter int LINE_BEATS = 16
) (
   input  logic         Clk,
   input  logic         Rest,
   input  logic         InReadAble,
   input  logic         InUncacheRead,
   input  logic [31:0]  InReadAddr,
   output logic         OutShankhand,
   output logic         OutReadreq,
   output logic         OutReadBackAble,
   output logic [511:0] OutReadBackDate,
   output logic         OutBusErr,
   output logic         OutArValid,
   output logic [31:0]  OutArAddr,
   output logic [7:0]   OutArLen,
   output logic [2:0]   OutArSize,
   output logic [1:0]   OutArBurst,
   input  logic         InArReady,
   input  logic         InRValid,
   input  logic [31:0]  InRData,
   input  logic [1:0]   InRResp,
   input  logic         InRLast,
   output logic         OutRReady
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} stateE;

   stateE        state, stateNext;
   logic [31:0]  addrQ;
   logic         uncacheQ;
   logic         firstAddr;
   logic [3:0]   cnt;
   logic         errQ;
   logic [511:0] lineBuf;

   wire acceptReq = (state == IDLE) && InReadAble;
   wire beatTaken = (state == DATA) && InRValid;

   // NOTE: every register here is written with <= so all flops update from
   // the same pre-edge values; the line buffer is plain flops, so it is reset.
   always_ff @(posedge Clk) begin
      if (Rest) begin
         state     <= IDLE;
         addrQ     <= '0;
         uncacheQ  <= 1'b0;
         firstAddr <= 1'b0;
         cnt       <= '0;
         errQ      <= 1'b0;
         lineBuf   <= '0;
      end else begin
         state     <= stateNext;
         firstAddr <= acceptReq;
         if (acceptReq) begin
            addrQ    <= InReadAddr;
            uncacheQ <= InUncacheRead;
            lineBuf  <= '0;
            errQ     <= 1'b0;
         end
         if ((state == ADDR) && InArReady)
            cnt <= '0;
         if (beatTaken) begin
            lineBuf[{cnt, 5'b0} +: 32] <= InRData;
            cnt <= cnt + 4'd1;
            if (InRResp != 2'b00)
               errQ <= 1'b1;
         end
      end
   end

   // NOTE: all outputs and stateNext get a default first so no path infers a latch.
   always_comb begin
      stateNext       = state;
      OutShankhand    = 1'b0;
      OutReadreq      = 1'b0;
      OutReadBackAble = 1'b0;
      OutReadBackDate = '0;
      OutBusErr       = 1'b0;
      OutArValid      = 1'b0;
      OutArAddr       = '0;
      OutArLen        = '0;
      OutArSize       = '0;
      OutArBurst      = '0;
      OutRReady       = 1'b0;
      unique case (state)
         IDLE: begin
            if (InReadAble)
               stateNext = ADDR;
         end
         ADDR: begin
            OutShankhand = firstAddr;
            OutReadreq   = 1'b1;
            OutArValid   = 1'b1;
            // Uncached fetches are word aligned, refills are line aligned.
            OutArAddr    = addrQ & (uncacheQ ? 32'hFFFF_FFFC : 32'hFFFF_FFC0);
            OutArLen     = uncacheQ ? 8'd0 : 8'(LINE_BEATS - 1);
            OutArSize    = 3'b010;
            OutArBurst   = 2'b01;
            if (InArReady)
               stateNext = DATA;
         end
         DATA: begin
            OutReadreq = 1'b1;
            OutRReady  = 1'b1;
            // A refill also closes on its last slot, guarding against a missing RLast.
            if (InRValid && (InRLast || (!uncacheQ && (cnt == 4'(LINE_BEATS - 1)))))
               stateNext = DONE;
         end
         DONE: begin
            OutReadreq      = 1'b1;
            OutReadBackAble = 1'b1;
            OutReadBackDate = lineBuf;
            OutBusErr       = errQ;
            stateNext       = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

endmodule

// File: tb/tb_icache_refill_reader.sv
// Scoreboard bench for icache_refill_reader: stimulus pushes expected returns,
// a negedge monitor pops and compares them against each OutReadBackAble pulse.
module tb_icache_refill_reader;

   logic         Clk = 1'b0;
   logic         Rest;
   logic         InReadAble, InUncacheRead;
   logic [31:0]  InReadAddr;
   logic         OutShankhand, OutReadreq, OutReadBackAble, OutBusErr;
   logic [511:0] OutReadBackDate;
   logic         OutArValid;
   logic [31:0]  OutArAddr;
   logic [7:0]   OutArLen;
   logic [2:0]   OutArSize;
   logic [1:0]   OutArBurst;
   logic         InArReady, InRValid, InRLast, OutRReady;
   logic [31:0]  InRData;
   logic [1:0]   InRResp;

   icache_refill_reader #(.LINE_BEATS(16)) dut (
      .Clk(Clk), .Rest(Rest),
      .InReadAble(InReadAble), .InUncacheRead(InUncacheRead), .InReadAddr(InReadAddr),
      .OutShankhand(OutShankhand), .OutReadreq(OutReadreq),
      .OutReadBackAble(OutReadBackAble), .OutReadBackDate(OutReadBackDate),
      .OutBusErr(OutBusErr), .OutArValid(OutArValid), .OutArAddr(OutArAddr),
      .OutArLen(OutArLen), .OutArSize(OutArSize), .OutArBurst(OutArBurst),
      .InArReady(InArReady), .InRValid(InRValid), .InRData(InRData),
      .InRResp(InRResp), .InRLast(InRLast), .OutRReady(OutRReady)
   );

   always #5 Clk = ~Clk;

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   typedef struct {
      logic [511:0] line;
      logic         err;
      int           delta;   // cycles from handshake pulse to return pulse
   } expT;

   expT sbq[$];
   int  errors = 0;
   int  checks = 0;
   int  shankCyc = 0;

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge Clk) begin : monitor
      expT e;
      if (OutShankhand)
         shankCyc = cyc;
      if (OutReadBackAble) begin
         if (sbq.size() == 0) begin
            check("unexpected return", 1, 0);
         end else begin
            e = sbq.pop_front();
            check("line", OutReadBackDate, e.line);
            check("buserr", OutBusErr, e.err);
            check("return latency", cyc - shankCyc, e.delta);
         end
      end
   end

   task automatic runReq(input logic [31:0] addr, input logic unc,
                         input logic [31:0] expAr, input logic [7:0] expLen,
                         input int arDelay, input int nBeats, input bit gaps,
                         input bit noLast, input logic [31:0] base,
                         input int errBeat, input int resetBeat);
      expT e;
      int  reqCyc;
      int  n;
      e.line = '0;
      for (int i = 0; i < nBeats; i++)
         e.line[i*32 +: 32] = base + 32'(i);
      e.err   = (errBeat >= 0) && (errBeat < nBeats);
      e.delta = 1 + arDelay + nBeats + (gaps ? nBeats : 0);
      if (resetBeat < 0)
         sbq.push_back(e);

      @(negedge Clk);
      InReadAble = 1'b1; InReadAddr = addr; InUncacheRead = unc;
      reqCyc = cyc;
      n = 0;
      do begin
         @(negedge Clk);
         n++;
      end while (!OutShankhand && n < 8);
      check("shankhand seen", OutShankhand, 1);
      check("shankhand latency", cyc - reqCyc, 1);
      // Request inputs are scrambled once accepted; the latched copy must win.
      InReadAble = 1'b0; InReadAddr = 32'h5555_5555; InUncacheRead = ~unc;
      check("ar beat", {OutArValid, OutArAddr, OutArLen}, {1'b1, expAr, expLen});
      check("ar size/burst", {OutArSize, OutArBurst}, {3'b010, 2'b01});
      check("readreq in addr", OutReadreq, 1);
      for (int d = 0; d < arDelay; d++) begin
         @(negedge Clk);
         check("ar stable", {OutArValid, OutArAddr, OutArLen, OutShankhand}, {1'b1, expAr, expLen, 1'b0});
      end
      InArReady = 1'b1;
      @(negedge Clk);
      InArReady = 1'b0;
      check("rready in data", {OutRReady, OutArValid}, 2'b10);

      for (int i = 0; i < nBeats; i++) begin
         if (i == resetBeat) begin
            Rest = 1'b1; InRValid = 1'b0;
            @(negedge Clk);
            check("reset date", OutReadBackDate, 0);
            check("reset ctl", {OutShankhand, OutReadreq, OutReadBackAble, OutBusErr, OutArValid,
                                OutArAddr, OutArLen, OutArSize, OutArBurst, OutRReady}, 0);
            Rest = 1'b0;
            return;
         end
         if (gaps) begin
            InRValid = 1'b0;
            @(negedge Clk);
         end
         InRValid = 1'b1;
         InRData  = base + 32'(i);
         InRResp  = (i == errBeat) ? 2'b10 : 2'b00;
         InRLast  = !noLast && (i == nBeats - 1);
         @(negedge Clk);
      end
      InRValid = 1'b0; InRLast = 1'b0; InRResp = 2'b00;

      n = 0;
      while (OutReadreq && n < 50) begin
         @(negedge Clk);
         n++;
      end
      check("back to idle", OutReadreq, 0);
      check("idle outputs", {OutArValid, OutArAddr, OutRReady, OutReadBackAble}, 0);
      check("idle date", OutReadBackDate, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      Rest = 1'b1;
      InReadAble = 1'b0; InUncacheRead = 1'b0; InReadAddr = '0;
      InArReady = 1'b0; InRValid = 1'b0; InRData = '0; InRResp = '0; InRLast = 1'b0;
      repeat (3) @(negedge Clk);
      check("reset date", OutReadBackDate, 0);
      check("reset ctl", {OutShankhand, OutReadreq, OutReadBackAble, OutBusErr, OutArValid,
                          OutArAddr, OutArLen, OutArSize, OutArBurst, OutRReady}, 0);
      Rest = 1'b0;

      // addr, unc, expAr, expLen, arDelay, nBeats, gaps, noLast, base, errBeat, resetBeat
      runReq(32'h1C00_0044, 1'b0, 32'h1C00_0040, 8'd15, 0, 16, 1'b0, 1'b0, 32'h0000_0000, -1, -1);
      runReq(32'hBFD0_0003, 1'b1, 32'hBFD0_0000, 8'd0,  0, 1,  1'b0, 1'b0, 32'hDEAD_BEEF, -1, -1);
      runReq(32'h0000_1234, 1'b0, 32'h0000_1200, 8'd15, 4, 16, 1'b1, 1'b1, 32'h1000_0000, -1, -1);
      runReq(32'h8000_00FC, 1'b0, 32'h8000_00C0, 8'd15, 0, 16, 1'b0, 1'b0, 32'hA500_0000, 7,  -1);
      runReq(32'h0000_0040, 1'b0, 32'h0000_0040, 8'd15, 1, 16, 1'b0, 1'b0, 32'h2000_0000, -1, -1);
      runReq(32'h1234_5678, 1'b0, 32'h1234_5640, 8'd15, 0, 6,  1'b0, 1'b0, 32'h3000_0000, -1, -1);
      runReq(32'h4000_0000, 1'b0, 32'h4000_0000, 8'd15, 0, 16, 1'b0, 1'b0, 32'h4400_0000, -1, 9);
      repeat (3) @(negedge Clk);
      runReq(32'h0000_0013, 1'b1, 32'h0000_0010, 8'd0,  2, 1,  1'b0, 1'b0, 32'hCAFE_F00D, -1, -1);

      repeat (4) @(negedge Clk);
      check("scoreboard drained", sbq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
